reg_file_seq: RTL and testbench

- Command sequencer and initiator for the register file; it owns that block's write and read ports.
- Accepts single or burst read/write commands from a host over a valid/ready interface.
- Drives address_w/data_w/WE and address_r toward the register file, samples data_r, and returns read data over a valid/ready response channel.
- Sits between the control logic and reg_file, so no other block drives reg_file ports directly.

---
 rtl/reg_file_seq_if.sv | 28 ++
 rtl/reg_file_seq.sv | 153 +++++++++++++++
 tb/tb_reg_file_seq.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_seq_if.sv
// reg_file_seq_if: host-side command/response bundle for reg_file_seq.
//   cmd_*  : command channel (valid/ready), op/addr/len/data from the host.
//   rsp_*  : read-response channel (valid/ready), data toward the host.
//   master : host view; slave : sequencer view.
interface reg_file_seq_if #(
  parameter int N    = 7,
  parameter int BITS = 4
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [1:0]      cmd_op;
  logic [N-1:0]    cmd_addr;
  logic [N-1:0]    cmd_len;
  logic [BITS-1:0] cmd_data;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [BITS-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/reg_file_seq.sv
// reg_file_seq: command sequencer / sole initiator for reg_file.
//   Accepts single or burst read/write commands on bus (reg_file_seq_if.slave),
//   drives reg_file write (address_w/data_w/WE) and read (address_r) ports,
//   samples data_r and returns read data on the response channel.
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   bus                   : cmd_valid/ready/op/addr/len/data, rsp_valid/ready/data
//   busy                  : state is not IDLE
//   err                   : sticky write-verify mismatch (0 unless verify built in)
//   address_w/data_w/WE   : reg_file write port
//   address_r/data_r      : reg_file read port (data_r combinational on address_r)
// Build option: define REG_SEQ_WRITE_VERIFY_EN to follow every write with a
//   read-back VERIFY cycle that compares data_r against data_w.
module reg_file_seq #(
  parameter int N    = 7,
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  reg_file_seq_if.slave   bus,
  output logic            busy,
  output logic            err,
  output logic [N-1:0]    address_w,
  output logic [BITS-1:0] data_w,
  output logic            WE,
  output logic [N-1:0]    address_r,
  input  logic [BITS-1:0] data_r
);

  localparam logic [N-1:0] ADDR_ONE = N'(1);
  localparam logic [N:0]   REM_ONE  = (N+1)'(1);
  localparam logic [N:0]   REM_FULL = {1'b1, {N{1'b0}}};

`ifdef REG_SEQ_WRITE_VERIFY_EN
  typedef enum logic [2:0] {IDLE, WRITE, READ, RSP, VERIFY} state_t;
`else
  typedef enum logic [2:0] {IDLE, WRITE, READ, RSP} state_t;
`endif

  state_t          state_q, state_d;
  logic [N-1:0]    cur_addr_q, cur_addr_d;
  logic [N:0]      remaining_q, remaining_d;
  logic [BITS-1:0] rsp_data_q, rsp_data_d;
  logic [BITS-1:0] data_w_q, data_w_d;
  logic [N-1:0]    address_r_q, address_r_d;
`ifdef REG_SEQ_WRITE_VERIFY_EN
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    rsp_data_d    = rsp_data_q;
    data_w_d      = data_w_q;
    address_r_d   = address_r_q;
`ifdef REG_SEQ_WRITE_VERIFY_EN
    err_d         = err_q;
`endif
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    WE            = 1'b0;

    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          cur_addr_d = bus.cmd_addr;
          data_w_d   = bus.cmd_data;
          if (!bus.cmd_op[1])          remaining_d = REM_ONE;
          else if (bus.cmd_len == '0)  remaining_d = REM_FULL;
          else                         remaining_d = {1'b0, bus.cmd_len};
          state_d = bus.cmd_op[0] ? READ : WRITE;
        end
      end
      WRITE: begin
        WE = 1'b1;
`ifdef REG_SEQ_WRITE_VERIFY_EN
        state_d = VERIFY;
`else
        cur_addr_d  = cur_addr_q + ADDR_ONE;
        remaining_d = remaining_q - REM_ONE;
        state_d     = (remaining_q == REM_ONE) ? IDLE : WRITE;
`endif
      end
`ifdef REG_SEQ_WRITE_VERIFY_EN
      VERIFY: begin
        if (data_r != data_w_q) err_d = 1'b1;
        cur_addr_d  = cur_addr_q + ADDR_ONE;
        remaining_d = remaining_q - REM_ONE;
        state_d     = (remaining_q == REM_ONE) ? IDLE : WRITE;
      end
`endif
      READ: begin
        rsp_data_d = data_r;
        state_d    = RSP;
      end
      RSP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          cur_addr_d  = cur_addr_q + ADDR_ONE;
          remaining_d = remaining_q - REM_ONE;
          state_d     = (remaining_q == REM_ONE) ? IDLE : READ;
        end
      end
      default: state_d = IDLE;
    endcase

    // address_r is registered, so it is loaded on entry to READ/VERIFY so that
    // data_r is valid throughout that cycle; it holds everywhere else.
    if (state_d == READ) address_r_d = cur_addr_d;
`ifdef REG_SEQ_WRITE_VERIFY_EN
    if (state_d == VERIFY) address_r_d = cur_addr_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rsp_data_q  <= '0;
      data_w_q    <= '0;
      address_r_q <= '0;
`ifdef REG_SEQ_WRITE_VERIFY_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rsp_data_q  <= rsp_data_d;
      data_w_q    <= data_w_d;
      address_r_q <= address_r_d;
`ifdef REG_SEQ_WRITE_VERIFY_EN
      err_q       <= err_d;
`endif
    end
  end

  // The write address always tracks the current burst pointer.
  assign address_w    = cur_addr_q;
  assign data_w       = data_w_q;
  assign address_r    = address_r_q;
  assign bus.rsp_data = rsp_data_q;
  assign busy         = (state_q != IDLE);
`ifdef REG_SEQ_WRITE_VERIFY_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_reg_file_seq.sv
// tb_reg_file_seq: scoreboard bench for reg_file_seq. A behavioural register
// file sits on the write/read ports; a reference memory predicts every write
// beat and every read response, and a negedge monitor pops and compares.
module tb_reg_file_seq;
  localparam int N     = 7;
  localparam int BITS  = 4;
  localparam int DEPTH = 128;
`ifdef REG_SEQ_WRITE_VERIFY_EN
  localparam int WMUL = 2;
`else
  localparam int WMUL = 1;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            busy, err, WE;
  logic [N-1:0]    address_w, address_r;
  logic [BITS-1:0] data_w, data_r;

  reg_file_seq_if #(.N(N), .BITS(BITS)) bus ();

  reg_file_seq #(.N(N), .BITS(BITS)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy), .err(err),
    .address_w(address_w), .data_w(data_w), .WE(WE),
    .address_r(address_r), .data_r(data_r)
  );

  always #5 clk = ~clk;

  // Register file environment (with optional read corruption).
  logic [BITS-1:0] rf [DEPTH];
  bit              corrupt = 1'b0;
  always @(posedge clk) if (WE === 1'b1) rf[address_w] <= data_w;
  assign data_r = rf[address_r] ^ (corrupt ? BITS'(1) : BITS'(0));

  // Reference model and scoreboard.
  typedef struct packed { logic [N-1:0] a; logic [BITS-1:0] d; } wr_t;
  logic [BITS-1:0] ref_mem [DEPTH];
  logic [BITS-1:0] saved_mem [DEPTH];
  wr_t             exp_wr [$];
  logic [BITS-1:0] exp_rd [$];
  int n_cmp = 0, n_bad = 0, rsp_count = 0, stall_checks = 0;
  int rdy_mode = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got event/timeout, expected none", name);
  endfunction

  function automatic void model_issue(logic [1:0] op, int a, int len, logic [BITS-1:0] d);
    int cnt;
    wr_t w;
    cnt = op[1] ? ((len == 0) ? DEPTH : len) : 1;
    for (int i = 0; i < cnt; i++) begin
      int ad;
      ad = (a + i) % DEPTH;
      if (!op[0]) begin
        ref_mem[ad] = d;
        w.a = N'(ad);
        w.d = d;
        exp_wr.push_back(w);
      end else begin
        exp_rd.push_back(ref_mem[ad]);
      end
    end
  endfunction

  // Monitor: write beats, response handshakes, and response hold under stall.
  wr_t             mon_w;
  logic [BITS-1:0] mon_d;
  bit              stall_prev = 1'b0;
  logic [BITS-1:0] prev_data;
  logic [N-1:0]    prev_ar;
  always @(negedge clk) begin
    if (WE === 1'b1) begin
      if (exp_wr.size() == 0) fail_evt("unexpected_we");
      else begin
        mon_w = exp_wr.pop_front();
        check("wr_addr", 32'(address_w), 32'(mon_w.a));
        check("wr_data", 32'(data_w), 32'(mon_w.d));
      end
    end
    if (stall_prev) begin
      stall_checks++;
      check("rsp_hold_valid", 32'(bus.rsp_valid), 1);
      check("rsp_hold_data", 32'(bus.rsp_data), 32'(prev_data));
      check("rsp_hold_addr_r", 32'(address_r), 32'(prev_ar));
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_rd.size() == 0) fail_evt("unexpected_rsp");
      else begin
        mon_d = exp_rd.pop_front();
        check("rsp_data", 32'(bus.rsp_data), 32'(mon_d));
      end
      rsp_count++;
    end
    stall_prev = (bus.rsp_valid === 1'b1) && (bus.rsp_ready !== 1'b1) && (reset_n === 1'b1);
    prev_data  = bus.rsp_data;
    prev_ar    = address_r;
  end

  // Host response-ready driver: 0 = always ready, 1 = random, 2 = 5-cycle stall per word.
  initial begin
    int stall_n;
    stall_n = 0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: bus.rsp_ready = 1'b1;
        1: bus.rsp_ready = 1'($urandom_range(0, 1));
        default: begin
          if (bus.rsp_valid !== 1'b1) begin
            bus.rsp_ready = 1'b0;
            stall_n = 0;
          end else if (stall_n < 5) begin
            bus.rsp_ready = 1'b0;
            stall_n++;
          end else begin
            bus.rsp_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic send_cmd(input logic [1:0] op, input int a, input int len, input logic [BITS-1:0] d);
    int w;
    bus.cmd_op    = op;
    bus.cmd_addr  = N'(a);
    bus.cmd_len   = N'(len);
    bus.cmd_data  = d;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (bus.cmd_ready !== 1'b1 && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    if (bus.cmd_ready !== 1'b1) begin
      fail_evt("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
      return;
    end
    model_issue(op, a, len, d);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cyc, output int we_cyc);
    busy_cyc = 0;
    we_cyc   = 0;
    while (busy === 1'b1 && busy_cyc < budget) begin
      busy_cyc++;
      if (WE === 1'b1) we_cyc++;
      @(posedge clk); #1;
    end
    if (busy !== 1'b0) fail_evt("busy_timeout");
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int bc, wc, r0, sc0, cnt;
    for (int i = 0; i < DEPTH; i++) begin
      rf[i]      = '0;
      ref_mem[i] = '0;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.cmd_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_we", 32'(WE), 0);
    check("rst_err", 32'(err), 0);
    check("rst_address_r", 32'(address_r), 0);
    check("rst_address_w", 32'(address_w), 0);
    check("rst_data_w", 32'(data_w), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single write then single read with latency check.
    send_cmd(2'b00, 5, 0, 4'hA);
    check("sw_we", 32'(WE), 1);
    check("sw_address_w", 32'(address_w), 5);
    wait_done(20, bc, wc);
    check("sw_busy_cycles", 32'(bc), 32'(WMUL));
    check("sw_we_cycles", 32'(wc), 1);
    send_cmd(2'b01, 5, 0, 4'h0);
    check("sr_valid_t1", 32'(bus.rsp_valid), 0);
    check("sr_address_r", 32'(address_r), 5);
    @(posedge clk); #1;
    check("sr_valid_t2", 32'(bus.rsp_valid), 1);
    check("sr_data_t2", 32'(bus.rsp_data), 32'h0A);
    wait_done(20, bc, wc);
    check("sr_busy_cycles", 32'(bc + 1), 2);

    // Fill with wrap, then dump back.
    send_cmd(2'b10, 126, 4, 4'h3);
    wait_done(50, bc, wc);
    check("fill_busy_cycles", 32'(bc), 32'(4 * WMUL));
    check("fill_we_cycles", 32'(wc), 4);
    check("fill_err", 32'(err), 0);
    r0 = rsp_count;
    send_cmd(2'b11, 126, 4, 4'h0);
    wait_done(50, bc, wc);
    check("dump_busy_cycles", 32'(bc), 8);
    check("dump_rsp_count", 32'(rsp_count - r0), 4);
    check("dump_cmd_ready", 32'(bus.cmd_ready), 1);

    // Full-depth fill and dump (len = 0).
    send_cmd(2'b10, 0, 0, 4'h6);
    wait_done(1000, bc, wc);
    check("fullfill_we_cycles", 32'(wc), 128);
    check("fullfill_busy_cycles", 32'(bc), 32'(128 * WMUL));
    r0 = rsp_count;
    send_cmd(2'b11, 37, 0, 4'h0);
    wait_done(1000, bc, wc);
    check("fulldump_rsp_count", 32'(rsp_count - r0), 128);
    check("fulldump_busy_cycles", 32'(bc), 256);

    // Backpressure: five stall cycles per word.
    rdy_mode = 2;
    @(posedge clk); #1;
    sc0 = stall_checks;
    r0  = rsp_count;
    send_cmd(2'b11, 10, 3, 4'h0);
    wait_done(200, bc, wc);
    check("bp_busy_cycles", 32'(bc), 21);
    check("bp_rsp_count", 32'(rsp_count - r0), 3);
    check("bp_stall_checks", 32'(stall_checks - sc0), 15);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset in the middle of a fill after three writes.
    saved_mem = ref_mem;
    send_cmd(2'b10, 0, 10, 4'h9);
    cnt = 0;
    wc  = 0;
    while (wc < 3 && cnt < 60) begin
      if (WE === 1'b1) wc++;
      if (wc == 3) break;
      @(posedge clk); #1;
      cnt++;
    end
    if (wc != 3) fail_evt("midfill_we_timeout");
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_we", 32'(WE), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("midrst_address_r", 32'(address_r), 0);
    reset_n = 1'b1;
    exp_wr.delete();
    ref_mem = saved_mem;
    for (int i = 0; i < 3; i++) ref_mem[i] = 4'h9;
    @(posedge clk); #1;
    check("midrst_no_we", 32'(WE), 0);
    send_cmd(2'b11, 0, 10, 4'h0);
    wait_done(100, bc, wc);

`ifdef REG_SEQ_WRITE_VERIFY_EN
    // Forced read-back corruption must set the sticky error.
    corrupt = 1'b1;
    send_cmd(2'b10, 20, 4, 4'h5);
    wait_done(50, bc, wc);
    corrupt = 1'b0;
    check("vfy_fill_cycles", 32'(bc), 8);
    check("vfy_err_set", 32'(err), 1);
    send_cmd(2'b00, 30, 0, 4'h7);
    wait_done(20, bc, wc);
    check("vfy_err_sticky", 32'(err), 1);
    do_reset();
    check("vfy_err_cleared", 32'(err), 0);
`else
    check("noverify_err", 32'(err), 0);
`endif

    // Randomized command mix with random response backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] op;
      int a, len;
      op  = 2'($urandom_range(0, 3));
      a   = int'($urandom_range(0, DEPTH - 1));
      len = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 6));
      send_cmd(op, a, len, 4'($urandom));
      wait_done(3000, bc, wc);
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    check("final_wr_queue_empty", 32'(exp_wr.size()), 0);
    check("final_rd_queue_empty", 32'(exp_rd.size()), 0);
    check("final_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
